// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and counter update rule for the PHT update path
package bp_pkg;

   localparam int BP_PC_W = 32;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } counter_e;

   typedef enum logic [1:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      WR
   } upd_state_e;

   typedef struct packed {
      logic [BP_PC_W-1:0] pc;
      logic               taken;
   } upd_entry_t;

   function automatic counter_e sat_next(counter_e cur, logic taken);
      counter_e res;
      if (taken) begin
         res = (cur == ST) ? ST : counter_e'(cur + 2'd1);
      end else begin
         res = (cur == SNT) ? SNT : counter_e'(cur - 2'd1);
      end
      return res;
   endfunction

endpackage

// File: rtl/bp_update_fifo.sv
// rtl/bp_update_fifo.sv - pending branch-update queue with flush that can spare the head
module bp_update_fifo
   import bp_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       push,
   input  upd_entry_t push_data,
   input  logic       pop,
   input  logic       flush,
   input  logic       keep_head,
   output upd_entry_t head,
   output logic       full,
   output logic       empty,
   output logic [AW:0] count
);

   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   upd_entry_t mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        do_push;

   assign count   = wr_ptr - rd_ptr;
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (wr_ptr == rd_ptr);
   assign head    = mem[rd_ptr[AW-1:0]];
   assign do_push = push && !full && !flush;

   // A flush keeps the in-flight head by pulling the write pointer back to just past it.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         if (flush) begin
            wr_ptr <= rd_ptr + {{AW{1'b0}}, keep_head};
         end else if (do_push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/bp_update_ctrl.sv
// rtl/bp_update_ctrl.sv - schedules resolved-branch read-modify-writes into the gshare PHT
module bp_update_ctrl
   import bp_pkg::*;
#(
   parameter int PC_W       = 32,
   parameter int INDEX_W    = 10,
   parameter int INDEX_LSB  = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               resolve_valid_i,
   input  logic [PC_W-1:0]    resolve_pc_i,
   input  logic               resolve_taken_i,
   output logic               resolve_ready_o,
   input  logic               flush_i,
   input  logic               lookup_req_i,
   output logic               tbl_rd_en_o,
   output logic               tbl_wr_en_o,
   output logic [INDEX_W-1:0] tbl_idx_o,
   input  logic [1:0]         tbl_rd_data_i,
   output logic [1:0]         tbl_wr_data_o,
   output logic [INDEX_W-1:0] ghr_o,
   output logic               busy_o
);

   localparam int CW = $clog2(FIFO_DEPTH);

   upd_state_e         state_q;
   upd_state_e         state_d;
   logic [INDEX_W-1:0] ghr_q;
   logic [INDEX_W-1:0] idx_q;
   logic [INDEX_W-1:0] head_idx;
   logic               taken_q;
   counter_e           next_q;

   upd_entry_t  push_entry;
   upd_entry_t  head;
   logic        fifo_full;
   logic        fifo_empty;
   logic [CW:0] fifo_count;
   logic        pop;
   logic        keep_head;

   assign push_entry.pc    = BP_PC_W'(resolve_pc_i);
   assign push_entry.taken = resolve_taken_i;
   assign keep_head        = (state_q == RD_WAIT) || (state_q == WR);

   bp_update_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .push      (resolve_valid_i),
      .push_data (push_entry),
      .pop       (pop),
      .flush     (flush_i),
      .keep_head (keep_head),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // The index is hashed with the live GHR, so it already reflects the previous entry's outcome.
   assign head_idx        = head.pc[INDEX_LSB +: INDEX_W] ^ ghr_q;
   assign resolve_ready_o = !fifo_full;
   assign ghr_o           = ghr_q;
   assign tbl_wr_data_o   = next_q;
   assign busy_o          = !fifo_empty || (state_q != IDLE);

   always_comb begin
      state_d     = state_q;
      tbl_rd_en_o = 1'b0;
      tbl_wr_en_o = 1'b0;
      tbl_idx_o   = idx_q;
      pop         = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty && !flush_i) begin
               state_d = RD_REQ;
            end
         end
         RD_REQ: begin
            tbl_idx_o = head_idx;
            if (flush_i) begin
               state_d = IDLE;
            end else if (!lookup_req_i) begin
               tbl_rd_en_o = 1'b1;
               state_d     = RD_WAIT;
            end
         end
         RD_WAIT: begin
            state_d = WR;
         end
         WR: begin
            if (!lookup_req_i) begin
               tbl_wr_en_o = 1'b1;
               pop         = 1'b1;
               state_d     = (fifo_count > (CW+1)'(1) && !flush_i) ? RD_REQ : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         ghr_q   <= '0;
         idx_q   <= '0;
         taken_q <= 1'b0;
         next_q  <= SNT;
      end else begin
         state_q <= state_d;
         if (tbl_rd_en_o) begin
            idx_q   <= head_idx;
            taken_q <= head.taken;
         end
         if (state_q == RD_WAIT) begin
            next_q <= sat_next(counter_e'(tbl_rd_data_i), taken_q);
         end
         if (pop) begin
            ghr_q <= {ghr_q[INDEX_W-2:0], taken_q};
         end
      end
   end

endmodule

// File: tb/tb_bp_update_ctrl.sv
// tb/tb_bp_update_ctrl.sv - directed self-checking bench for bp_update_ctrl
module tb_bp_update_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        resolve_valid_i = 1'b0;
   logic [31:0] resolve_pc_i = '0;
   logic        resolve_taken_i = 1'b0;
   logic        resolve_ready_o;
   logic        flush_i = 1'b0;
   logic        lookup_req_i = 1'b0;
   logic        tbl_rd_en_o;
   logic        tbl_wr_en_o;
   logic [9:0]  tbl_idx_o;
   logic [1:0]  tbl_rd_data_i = 2'b00;
   logic [1:0]  tbl_wr_data_o;
   logic [9:0]  ghr_o;
   logic        busy_o;

   int errors = 0;
   int checks = 0;

   always #5 clk_i = ~clk_i;

   bp_update_ctrl #(
      .PC_W       (32),
      .INDEX_W    (10),
      .INDEX_LSB  (2),
      .FIFO_DEPTH (4)
   ) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .resolve_valid_i (resolve_valid_i),
      .resolve_pc_i    (resolve_pc_i),
      .resolve_taken_i (resolve_taken_i),
      .resolve_ready_o (resolve_ready_o),
      .flush_i         (flush_i),
      .lookup_req_i    (lookup_req_i),
      .tbl_rd_en_o     (tbl_rd_en_o),
      .tbl_wr_en_o     (tbl_wr_en_o),
      .tbl_idx_o       (tbl_idx_o),
      .tbl_rd_data_i   (tbl_rd_data_i),
      .tbl_wr_data_o   (tbl_wr_data_o),
      .ghr_o           (ghr_o),
      .busy_o          (busy_o)
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      repeat (3) tick();
      #1;
      checks++; if (resolve_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", resolve_ready_o); end
      checks++; if (ghr_o !== 10'd0) begin errors++; $display("FAIL reset_ghr: got %0d want 0", ghr_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
      checks++; if ({tbl_rd_en_o, tbl_wr_en_o} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b want 00", {tbl_rd_en_o, tbl_wr_en_o}); end
      checks++; if (tbl_idx_o !== 10'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", tbl_idx_o); end
      checks++; if (tbl_wr_data_o !== 2'b00) begin errors++; $display("FAIL reset_wdata: got %b want 00", tbl_wr_data_o); end
      rst_i = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         #1;
         checks++; if ({tbl_rd_en_o, tbl_wr_en_o} !== 2'b00) begin errors++; $display("FAIL idle_strobe cycle %0d: got %b want 00", i, {tbl_rd_en_o, tbl_wr_en_o}); end
      end
   endtask

   task automatic test_single_update();
      tick();
      resolve_valid_i = 1'b1; resolve_pc_i = 32'h10; resolve_taken_i = 1'b1;
      #1;
      checks++; if (resolve_ready_o !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", resolve_ready_o); end
      tick();
      resolve_valid_i = 1'b0;
      #1;
      checks++; if (tbl_rd_en_o !== 1'b0) begin errors++; $display("FAIL single_rd_early: got %b want 0", tbl_rd_en_o); end
      checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy_o); end
      tick();
      #1;
      checks++; if (tbl_rd_en_o !== 1'b1) begin errors++; $display("FAIL single_rd_en: got %b want 1", tbl_rd_en_o); end
      checks++; if (tbl_idx_o !== 10'd4) begin errors++; $display("FAIL single_rd_idx: got %0d want 4", tbl_idx_o); end
      tbl_rd_data_i = 2'b01;
      tick();
      #1;
      checks++; if ({tbl_rd_en_o, tbl_wr_en_o} !== 2'b00) begin errors++; $display("FAIL single_wait_strobes: got %b want 00", {tbl_rd_en_o, tbl_wr_en_o}); end
      tick();
      #1;
      checks++; if (tbl_wr_en_o !== 1'b1) begin errors++; $display("FAIL single_wr_en: got %b want 1", tbl_wr_en_o); end
      checks++; if (tbl_idx_o !== 10'd4) begin errors++; $display("FAIL single_wr_idx: got %0d want 4", tbl_idx_o); end
      checks++; if (tbl_wr_data_o !== 2'b10) begin errors++; $display("FAIL single_wr_data: got %b want 10", tbl_wr_data_o); end
      tick();
      #1;
      checks++; if (ghr_o !== 10'd1) begin errors++; $display("FAIL single_ghr: got %0d want 1", ghr_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL single_idle: got %b want 0", busy_o); end
   endtask

   task automatic test_saturation();
      logic [31:0] pcs  [2] = '{32'h20, 32'h40};
      logic        tks  [2] = '{1'b1, 1'b0};
      logic [1:0]  rets [2] = '{2'b11, 2'b00};
      logic [9:0]  idxs [2] = '{10'd9, 10'd19};
      logic [1:0]  wds  [2] = '{2'b11, 2'b00};
      logic [9:0]  ghrs [2] = '{10'd3, 10'd6};
      for (int v = 0; v < 2; v++) begin
         tick();
         resolve_valid_i = 1'b1; resolve_pc_i = pcs[v]; resolve_taken_i = tks[v];
         tick();
         resolve_valid_i = 1'b0;
         tick();
         #1;
         checks++; if (tbl_rd_en_o !== 1'b1 || tbl_idx_o !== idxs[v]) begin errors++; $display("FAIL sat_rd vec %0d: got en=%b idx=%0d want en=1 idx=%0d", v, tbl_rd_en_o, tbl_idx_o, idxs[v]); end
         tbl_rd_data_i = rets[v];
         tick();
         tick();
         #1;
         checks++; if (tbl_wr_en_o !== 1'b1 || tbl_wr_data_o !== wds[v]) begin errors++; $display("FAIL sat_wr vec %0d: got en=%b data=%b want en=1 data=%b", v, tbl_wr_en_o, tbl_wr_data_o, wds[v]); end
         tick();
         #1;
         checks++; if (ghr_o !== ghrs[v]) begin errors++; $display("FAIL sat_ghr vec %0d: got %0d want %0d", v, ghr_o, ghrs[v]); end
      end
   endtask

   task automatic test_contention();
      tick();
      resolve_valid_i = 1'b1; resolve_pc_i = 32'h80; resolve_taken_i = 1'b0;
      tick();
      resolve_valid_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         lookup_req_i = 1'b1;
         #1;
         checks++; if ({tbl_rd_en_o, tbl_wr_en_o} !== 2'b00) begin errors++; $display("FAIL cont_rd_blocked cycle %0d: got %b want 00", i, {tbl_rd_en_o, tbl_wr_en_o}); end
      end
      tick();
      lookup_req_i = 1'b0;
      #1;
      checks++; if (tbl_rd_en_o !== 1'b1 || tbl_idx_o !== 10'd38) begin errors++; $display("FAIL cont_rd: got en=%b idx=%0d want en=1 idx=38", tbl_rd_en_o, tbl_idx_o); end
      tbl_rd_data_i = 2'b10;
      tick();
      #1;
      checks++; if ({tbl_rd_en_o, tbl_wr_en_o} !== 2'b00) begin errors++; $display("FAIL cont_wait: got %b want 00", {tbl_rd_en_o, tbl_wr_en_o}); end
      for (int i = 0; i < 2; i++) begin
         tick();
         lookup_req_i = 1'b1;
         #1;
         checks++; if ({tbl_rd_en_o, tbl_wr_en_o} !== 2'b00) begin errors++; $display("FAIL cont_wr_blocked cycle %0d: got %b want 00", i, {tbl_rd_en_o, tbl_wr_en_o}); end
      end
      tick();
      lookup_req_i = 1'b0;
      #1;
      checks++; if (tbl_wr_en_o !== 1'b1 || tbl_idx_o !== 10'd38 || tbl_wr_data_o !== 2'b01) begin errors++; $display("FAIL cont_wr: got en=%b idx=%0d data=%b want en=1 idx=38 data=01", tbl_wr_en_o, tbl_idx_o, tbl_wr_data_o); end
      tick();
      #1;
      checks++; if (ghr_o !== 10'd12 || busy_o !== 1'b0) begin errors++; $display("FAIL cont_done: got ghr=%0d busy=%b want ghr=12 busy=0", ghr_o, busy_o); end
   endtask

   task automatic test_full_fifo();
      logic       tks   [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      logic [9:0] exp_i [5] = '{10'd12, 10'd25, 10'd50, 10'd101, 10'd203};
      logic [1:0] exp_d [5] = '{2'b10, 2'b00, 2'b10, 2'b10, 2'b00};
      logic [9:0] w_idx [5];
      logic [1:0] w_dat [5];
      int np = 0, nw = 0, drop_at = -1, w_at_5th = -1, bad = 0;
      bit done = 1'b0;
      tbl_rd_data_i = 2'b01;
      for (int cyc = 0; cyc < 80 && !done; cyc++) begin
         tick();
         lookup_req_i    = (cyc < 8);
         resolve_valid_i = (np < 5);
         resolve_pc_i    = 32'h0;
         resolve_taken_i = (np < 5) ? tks[np] : 1'b0;
         #1;
         if ((tbl_rd_en_o || tbl_wr_en_o) && lookup_req_i) bad++;
         if (tbl_rd_en_o && tbl_wr_en_o) bad++;
         if (tbl_wr_en_o) begin
            if (nw < 5) begin w_idx[nw] = tbl_idx_o; w_dat[nw] = tbl_wr_data_o; end
            nw++;
         end
         if (resolve_valid_i && !resolve_ready_o && drop_at < 0) drop_at = np;
         if (resolve_valid_i && resolve_ready_o) begin
            if (np == 4) w_at_5th = nw;
            np++;
         end
         done = (np == 5) && (nw >= 5) && !busy_o;
      end
      resolve_valid_i = 1'b0;
      lookup_req_i    = 1'b0;
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL full_timeout: pushes=%0d writes=%0d want 5 and 5", np, nw); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL full_port_rules: got %0d violations want 0", bad); end
      checks++; if (drop_at !== 4) begin errors++; $display("FAIL full_ready_drop: got after %0d accepts want 4", drop_at); end
      checks++; if (w_at_5th !== 1) begin errors++; $display("FAIL full_fifth_accept: got after %0d writes want 1", w_at_5th); end
      for (int i = 0; i < 5; i++) begin
         checks++; if (w_idx[i] !== exp_i[i] || w_dat[i] !== exp_d[i]) begin errors++; $display("FAIL full_write %0d: got idx=%0d data=%b want idx=%0d data=%b", i, w_idx[i], w_dat[i], exp_i[i], exp_d[i]); end
      end
      checks++; if (ghr_o[4:0] !== 5'b10110 || ghr_o !== 10'd406) begin errors++; $display("FAIL full_ghr: got %b want 0110010110", ghr_o); end
   endtask

   task automatic test_flush();
      int strobes = 0;
      tbl_rd_data_i = 2'b01;
      tick();
      resolve_valid_i = 1'b1; resolve_pc_i = 32'h0; resolve_taken_i = 1'b1;
      tick();
      tick();
      #1;
      checks++; if (tbl_rd_en_o !== 1'b1 || tbl_idx_o !== 10'd406) begin errors++; $display("FAIL flush_rd: got en=%b idx=%0d want en=1 idx=406", tbl_rd_en_o, tbl_idx_o); end
      tick();
      flush_i = 1'b1;
      #1;
      checks++; if ({tbl_rd_en_o, tbl_wr_en_o} !== 2'b00) begin errors++; $display("FAIL flush_wait: got %b want 00", {tbl_rd_en_o, tbl_wr_en_o}); end
      tick();
      flush_i = 1'b0; resolve_valid_i = 1'b0;
      #1;
      checks++; if (tbl_wr_en_o !== 1'b1 || tbl_idx_o !== 10'd406 || tbl_wr_data_o !== 2'b10) begin errors++; $display("FAIL flush_head_wr: got en=%b idx=%0d data=%b want en=1 idx=406 data=10", tbl_wr_en_o, tbl_idx_o, tbl_wr_data_o); end
      tick();
      #1;
      checks++; if (resolve_ready_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL flush_empty: got ready=%b busy=%b want 1 0", resolve_ready_o, busy_o); end
      checks++; if (ghr_o !== 10'd813) begin errors++; $display("FAIL flush_ghr: got %0d want 813", ghr_o); end
      for (int i = 0; i < 5; i++) begin
         tick();
         #1;
         if (tbl_rd_en_o || tbl_wr_en_o) strobes++;
      end
      checks++; if (strobes !== 0) begin errors++; $display("FAIL flush_no_more: got %0d strobes want 0", strobes); end
   endtask

   task automatic test_reset_in_wr();
      int strobes = 0;
      tbl_rd_data_i = 2'b01;
      tick();
      resolve_valid_i = 1'b1; resolve_pc_i = 32'h0; resolve_taken_i = 1'b0;
      tick();
      resolve_valid_i = 1'b0;
      tick();
      tick();
      tick();
      #1;
      checks++; if (tbl_wr_en_o !== 1'b1) begin errors++; $display("FAIL rstwr_pre: got %b want 1", tbl_wr_en_o); end
      #1;
      rst_i = 1'b1;
      #1;
      checks++; if (tbl_wr_en_o !== 1'b0) begin errors++; $display("FAIL rstwr_wr_en: got %b want 0", tbl_wr_en_o); end
      checks++; if (ghr_o !== 10'd0 || busy_o !== 1'b0) begin errors++; $display("FAIL rstwr_state: got ghr=%0d busy=%b want 0 0", ghr_o, busy_o); end
      tick();
      rst_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         #1;
         if (tbl_rd_en_o || tbl_wr_en_o) strobes++;
      end
      checks++; if (strobes !== 0) begin errors++; $display("FAIL rstwr_after: got %0d strobes want 0", strobes); end
   endtask

   initial begin
      test_reset();
      test_single_update();
      test_saturation();
      test_contention();
      test_full_fifo();
      test_flush();
      test_reset_in_wr();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
